// File: rtl/udma_i2c_cmd_arbiter.sv
// udma_i2c_cmd_arbiter: shares one udma_i2c_control command stream between NB_REQ requesters,
// locking per I2C transaction. Optional owner-idle forced release: define I2C_ARB_TIMEOUT_EN.
module udma_i2c_cmd_arbiter #(
  parameter int unsigned NB_REQ      = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                sw_rst_i,
  input  logic [NB_REQ*8-1:0] req_data_i,
  input  logic [NB_REQ-1:0]   req_valid_i,
  output logic [NB_REQ-1:0]   req_ready_o,
  output logic [7:0]          req_rx_data_o,
  output logic [NB_REQ-1:0]   req_rx_valid_o,
  input  logic [NB_REQ-1:0]   req_rx_ready_i,
  output logic [NB_REQ-1:0]   req_eot_o,
  output logic [2:0]          owner_o,
  output logic                busy_o,
  output logic [7:0]          ctrl_tx_data_o,
  output logic                ctrl_tx_valid_o,
  input  logic                ctrl_tx_ready_i,
  input  logic [7:0]          ctrl_rx_data_i,
  input  logic                ctrl_rx_valid_i,
  output logic                ctrl_rx_ready_o,
  input  logic                ctrl_eot_i,
  output logic                timeout_o
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  localparam logic [1:0] PS_CMD    = 2'd0;
  localparam logic [1:0] PS_ARG    = 2'd1;
  localparam logic [1:0] PS_RPTARG = 2'd2;
  localparam logic [1:0] PS_SKIP   = 2'd3;
  localparam logic [2:0] PTR_RST   = 3'(NB_REQ - 1);

  if (NB_REQ < 2 || NB_REQ > 8 || TIMEOUT_CYC == 0) begin : g_bad_param
    $error("udma_i2c_cmd_arbiter: NB_REQ must be 2..8 and TIMEOUT_CYC nonzero");
  end

  logic [0:0]        state_q, state_d;
  logic [2:0]        owner_q, owner_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [1:0]        pst_q, pst_d;
  logic [7:0]        rpt_q, rpt_d;
  logic [8:0]        cnt_q, cnt_d;

  logic              locked, accepted, rel_cmd, tmo_fire;
  logic [7:0]        own_data;
  logic              own_valid, own_rx_ready;
  logic [NB_REQ-1:0] owner_oh;
  logic              found_hi, found_lo;
  logic [2:0]        pick_hi, pick_lo, pick;

  assign locked = (state_q == ST_LOCKED);

  always_comb begin
    own_data     = '0;
    own_valid    = 1'b0;
    own_rx_ready = 1'b0;
    owner_oh     = '0;
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      if (owner_q == 3'(i)) begin
        own_data     = req_data_i[8*i +: 8];
        own_valid    = req_valid_i[i];
        own_rx_ready = req_rx_ready_i[i];
        owner_oh[i]  = 1'b1;
      end
    end
  end

  // Round-robin: lowest requester above ptr wins, else wrap to lowest at or below ptr.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      if (req_valid_i[i]) begin
        if (3'(i) > ptr_q) begin
          if (!found_hi) begin
            pick_hi  = 3'(i);
            found_hi = 1'b1;
          end
        end else if (!found_lo) begin
          pick_lo  = 3'(i);
          found_lo = 1'b1;
        end
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  assign ctrl_tx_data_o  = locked ? own_data : '0;
  assign ctrl_tx_valid_o = locked & own_valid & ~sw_rst_i;
  assign accepted        = ctrl_tx_valid_o & ctrl_tx_ready_i;
  assign req_ready_o     = sw_rst_i ? '1 : ((locked && ctrl_tx_ready_i) ? owner_oh : '0);
  assign ctrl_rx_ready_o = sw_rst_i | ~locked | own_rx_ready;
  assign req_rx_data_o   = ctrl_rx_data_i;
  assign req_rx_valid_o  = (locked && ctrl_rx_valid_i && !sw_rst_i) ? owner_oh : '0;
  assign req_eot_o       = (locked && ctrl_eot_i) ? owner_oh : '0;
  assign owner_o         = owner_q;
  assign busy_o          = locked;

  // Only CMD-position STOP/EOT opcodes release; the same values as arguments are payload.
  always_comb begin
    pst_d   = pst_q;
    rpt_d   = rpt_q;
    cnt_d   = cnt_q;
    rel_cmd = 1'b0;
    if (accepted) begin
      case (pst_q)
        PS_CMD: begin
          case (own_data[7:4])
            4'hA: begin
              cnt_d = 9'd1;
              pst_d = PS_ARG;
            end
            4'hC: pst_d = PS_RPTARG;
            4'hE: begin
              cnt_d = 9'd2;
              pst_d = PS_ARG;
            end
            4'h8: begin
              cnt_d = {1'b0, rpt_q};
              rpt_d = 8'd1;
              pst_d = PS_ARG;
            end
            4'h2, 4'h9: begin
              rel_cmd = 1'b1;
              rpt_d   = 8'd1;
            end
            default: rpt_d = 8'd1;
          endcase
        end
        PS_RPTARG: begin
          if (own_data == 8'd0) begin
            pst_d = PS_SKIP;
          end else begin
            rpt_d = own_data;
            pst_d = PS_CMD;
          end
        end
        PS_ARG: begin
          cnt_d = cnt_q - 9'd1;
          if (cnt_q == 9'd1) pst_d = PS_CMD;
        end
        default: pst_d = PS_CMD;
      endcase
    end
    if (sw_rst_i) begin
      pst_d = PS_CMD;
      rpt_d = 8'd1;
      cnt_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (state_q == ST_IDLE) begin
      if (|req_valid_i) begin
        owner_d = pick;
        state_d = ST_LOCKED;
      end
    end else if (rel_cmd || tmo_fire) begin
      state_d = ST_IDLE;
      ptr_d   = owner_q;
    end
    if (sw_rst_i) begin
      state_d = ST_IDLE;
      ptr_d   = PTR_RST;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= PTR_RST;
      pst_q   <= PS_CMD;
      rpt_q   <= 8'd1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      pst_q   <= pst_d;
      rpt_q   <= rpt_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_idle;
  logic          tmo_pulse_q;

  // Idle means between commands with the owner presenting nothing.
  assign tmo_idle = locked & (pst_q == PS_CMD) & ~own_valid & ~sw_rst_i;
  assign tmo_fire = tmo_idle & (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (!locked || accepted || sw_rst_i || tmo_fire) tmo_cnt_d = '0;
    else if (tmo_idle)                               tmo_cnt_d = tmo_cnt_q + TW'(1);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tmo_cnt_q   <= '0;
      tmo_pulse_q <= 1'b0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_pulse_q <= tmo_fire;
    end
  end

  assign timeout_o = tmo_pulse_q;
`else
  assign tmo_fire  = 1'b0;
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_udma_i2c_cmd_arbiter.sv
// Directed bench for udma_i2c_cmd_arbiter with two requesters and hand-computed expectations.
module tb_udma_i2c_cmd_arbiter;

  logic        clk;
  logic        rstn;
  logic        sw_rst;
  logic [15:0] req_data;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready_o;
  logic [7:0]  req_rx_data_o;
  logic [1:0]  req_rx_valid_o;
  logic [1:0]  req_rx_ready;
  logic [1:0]  req_eot_o;
  logic [2:0]  owner_o;
  logic        busy_o;
  logic [7:0]  ctrl_tx_data_o;
  logic        ctrl_tx_valid_o;
  logic        ctrl_tx_ready;
  logic [7:0]  ctrl_rx_data;
  logic        ctrl_rx_valid;
  logic        ctrl_rx_ready_o;
  logic        ctrl_eot;
  logic        timeout_o;

  int errors = 0;
  int checks = 0;

  logic [7:0] cap_data [0:15];
  logic [2:0] cap_own  [0:15];
  int         cap_n;

  udma_i2c_cmd_arbiter #(
    .NB_REQ      (2),
    .TIMEOUT_CYC (1024)
  ) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .sw_rst_i        (sw_rst),
    .req_data_i      (req_data),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready_o),
    .req_rx_data_o   (req_rx_data_o),
    .req_rx_valid_o  (req_rx_valid_o),
    .req_rx_ready_i  (req_rx_ready),
    .req_eot_o       (req_eot_o),
    .owner_o         (owner_o),
    .busy_o          (busy_o),
    .ctrl_tx_data_o  (ctrl_tx_data_o),
    .ctrl_tx_valid_o (ctrl_tx_valid_o),
    .ctrl_tx_ready_i (ctrl_tx_ready),
    .ctrl_rx_data_i  (ctrl_rx_data),
    .ctrl_rx_valid_i (ctrl_rx_valid),
    .ctrl_rx_ready_o (ctrl_rx_ready_o),
    .ctrl_eot_i      (ctrl_eot),
    .timeout_o       (timeout_o)
  );

  always #5 clk = ~clk;

  // Presents n bytes (MSB-first in bytes) from requester r, each held until accepted;
  // records what the control side saw. Returns on the negedge after the last acceptance.
  task automatic send(input int r, input logic [63:0] bytes, input int n, input bit keep,
                      output bit tmo);
    int waits;
    tmo = 1'b0;
    for (int j = 0; j < n; j++) begin
      req_data[8*r +: 8] = bytes[8*(n-1-j) +: 8];
      req_valid[r] = 1'b1;
      waits = 0;
      #1;
      while (!req_ready_o[r]) begin
        @(negedge clk);
        #1;
        waits++;
        if (waits > 50) begin
          tmo = 1'b1;
          req_valid[r] = 1'b0;
          return;
        end
      end
      if (ctrl_tx_valid_o && cap_n < 16) begin
        cap_data[cap_n] = ctrl_tx_data_o;
        cap_own[cap_n]  = owner_o;
        cap_n++;
      end
      @(negedge clk);
    end
    if (!keep) req_valid[r] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
    checks++;
    if (owner_o !== 3'd0) begin errors++; $display("FAIL rst_owner: got %0d expected 0", owner_o); end
    checks++;
    if (req_ready_o !== 2'b00) begin errors++; $display("FAIL rst_req_ready: got %b expected 00", req_ready_o); end
    checks++;
    if (ctrl_tx_valid_o !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: got %b expected 0", ctrl_tx_valid_o); end
    checks++;
    if ({req_rx_valid_o, req_eot_o, timeout_o} !== 5'b0) begin
      errors++; $display("FAIL rst_misc: got %b expected 00000", {req_rx_valid_o, req_eot_o, timeout_o});
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_atomic_wr();
    logic [31:0] exp;
    bit tmo;
    exp = 32'h00_80_A5_20;
    cap_n = 0;
    req_data[15:8] = 8'h00;
    req_valid[1] = 1'b1;
    send(0, 64'h00_80_A5_20, 4, 1'b0, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL atomic_grant_r0: got timeout expected grant"); end
    checks++;
    if (cap_n !== 4) begin errors++; $display("FAIL atomic_count: got %0d expected 4", cap_n); end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (cap_data[j] !== exp[8*(3-j) +: 8] || cap_own[j] !== 3'd0) begin
        errors++;
        $display("FAIL atomic_byte%0d: got %h/owner%0d expected %h/owner0", j, cap_data[j], cap_own[j],
                 exp[8*(3-j) +: 8]);
      end
    end
    #1;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL atomic_release: got busy %b expected 0", busy_o); end
    @(negedge clk);
    #1;
    checks++;
    if (owner_o !== 3'd1 || busy_o !== 1'b1) begin
      errors++; $display("FAIL atomic_r1_grant: got owner %0d busy %b expected 1 1", owner_o, busy_o);
    end
    send(1, 64'h20, 1, 1'b0, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL atomic_r1_send: got timeout expected accept"); end
  endtask

  task automatic test_rpt_payload();
    logic [55:0] exp;
    bit tmo;
    exp = 56'hC0_03_80_20_21_22_20;
    cap_n = 0;
    send(0, 64'hC0_03_80_20_21_22, 6, 1'b0, tmo);
    #1;
    checks++;
    if (tmo || busy_o !== 1'b1) begin
      errors++; $display("FAIL rpt_lock_held: got busy %b tmo %b expected 1 0", busy_o, tmo);
    end
    ctrl_tx_ready = 1'b0;
    req_data[7:0] = 8'h20;
    req_valid[0] = 1'b1;
    #1;
    checks++;
    if (ctrl_tx_valid_o !== 1'b1 || req_ready_o !== 2'b00) begin
      errors++; $display("FAIL rpt_backpressure: got valid %b ready %b expected 1 00", ctrl_tx_valid_o, req_ready_o);
    end
    @(negedge clk);
    ctrl_tx_ready = 1'b1;
    send(0, 64'h20, 1, 1'b0, tmo);
    #1;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL rpt_stop_release: got busy %b expected 0", busy_o); end
    checks++;
    if (cap_n !== 7) begin errors++; $display("FAIL rpt_count: got %0d expected 7", cap_n); end
    for (int j = 0; j < 7; j++) begin
      checks++;
      if (cap_data[j] !== exp[8*(6-j) +: 8]) begin
        errors++; $display("FAIL rpt_byte%0d: got %h expected %h", j, cap_data[j], exp[8*(6-j) +: 8]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    bit tmo;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    req_data  = 16'h20_20;
    req_valid = 2'b11;
    @(negedge clk);
    #1;
    checks++;
    if (owner_o !== 3'd0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL rr_first: got owner %0d busy %b expected 0 1", owner_o, busy_o);
    end
    send(0, 64'h20, 1, 1'b1, tmo);
    #1;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL rr_idle_gap1: got busy %b expected 0", busy_o); end
    @(negedge clk);
    #1;
    checks++;
    if (owner_o !== 3'd1 || busy_o !== 1'b1) begin
      errors++; $display("FAIL rr_second: got owner %0d busy %b expected 1 1", owner_o, busy_o);
    end
    send(1, 64'h20, 1, 1'b1, tmo);
    #1;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL rr_idle_gap2: got busy %b expected 0", busy_o); end
    @(negedge clk);
    #1;
    checks++;
    if (owner_o !== 3'd0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL rr_third: got owner %0d busy %b expected 0 1", owner_o, busy_o);
    end
    send(0, 64'h20, 1, 1'b0, tmo);
    req_valid[1] = 1'b0;
    checks++;
    if (tmo) begin errors++; $display("FAIL rr_send: got timeout expected accept"); end
    @(negedge clk);
  endtask

  task automatic test_rx_route();
    bit tmo;
    send(1, 64'h00_40, 2, 1'b0, tmo);
    ctrl_rx_data  = 8'h5A;
    ctrl_rx_valid = 1'b1;
    req_rx_ready  = 2'b10;
    #1;
    checks++;
    if (req_rx_valid_o !== 2'b10) begin errors++; $display("FAIL rx_valid_owner: got %b expected 10", req_rx_valid_o); end
    checks++;
    if (req_rx_data_o !== 8'h5A) begin errors++; $display("FAIL rx_data: got %h expected 5a", req_rx_data_o); end
    checks++;
    if (ctrl_rx_ready_o !== 1'b1) begin errors++; $display("FAIL rx_ready_owner: got %b expected 1", ctrl_rx_ready_o); end
    req_rx_ready = 2'b01;
    #1;
    checks++;
    if (ctrl_rx_ready_o !== 1'b0) begin errors++; $display("FAIL rx_ready_nonowner: got %b expected 0", ctrl_rx_ready_o); end
    ctrl_rx_valid = 1'b0;
    req_rx_ready  = 2'b00;
    @(negedge clk);
    send(1, 64'h20, 1, 1'b0, tmo);
    ctrl_rx_valid = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || req_rx_valid_o !== 2'b00 || ctrl_rx_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rx_idle_drop: got busy %b rx_valid %b rx_ready %b expected 0 00 1",
               busy_o, req_rx_valid_o, ctrl_rx_ready_o);
    end
    ctrl_rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_skip_eot();
    bit tmo;
    send(0, 64'hC0_00_20, 3, 1'b0, tmo);
    #1;
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL skip_no_release: got busy %b expected 1", busy_o); end
    ctrl_eot = 1'b1;
    #1;
    checks++;
    if (req_eot_o !== 2'b01) begin errors++; $display("FAIL eot_route: got %b expected 01", req_eot_o); end
    ctrl_eot = 1'b0;
    @(negedge clk);
    send(0, 64'h90, 1, 1'b0, tmo);
    #1;
    checks++;
    if (busy_o !== 1'b0 || owner_o !== 3'd0) begin
      errors++; $display("FAIL eot_release: got busy %b owner %0d expected 0 0", busy_o, owner_o);
    end
    @(negedge clk);
  endtask

  task automatic test_sw_rst();
    bit tmo;
    send(0, 64'hC0_04_80_11, 4, 1'b0, tmo);
    sw_rst        = 1'b1;
    ctrl_rx_valid = 1'b1;
    req_data[7:0] = 8'h20;
    req_valid[0]  = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 2'b11 || ctrl_tx_valid_o !== 1'b0 || req_rx_valid_o !== 2'b00) begin
      errors++;
      $display("FAIL swrst_flush: got ready %b tx_valid %b rx_valid %b expected 11 0 00",
               req_ready_o, ctrl_tx_valid_o, req_rx_valid_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b0 || req_ready_o !== 2'b11) begin
      errors++; $display("FAIL swrst_idle: got busy %b ready %b expected 0 11", busy_o, req_ready_o);
    end
    sw_rst         = 1'b0;
    ctrl_rx_valid  = 1'b0;
    req_data[15:8] = 8'h20;
    req_valid      = 2'b11;
    @(negedge clk);
    #1;
    checks++;
    if (owner_o !== 3'd0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL swrst_ptr: got owner %0d busy %b expected 0 1", owner_o, busy_o);
    end
    send(0, 64'h20, 1, 1'b0, tmo);
    req_valid[1] = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL swrst_parser_cmd: got busy %b expected 0", busy_o); end
    @(negedge clk);
  endtask

  initial begin
    clk           = 1'b0;
    rstn          = 1'b0;
    sw_rst        = 1'b0;
    req_data      = '0;
    req_valid     = '0;
    req_rx_ready  = '0;
    ctrl_tx_ready = 1'b1;
    ctrl_rx_data  = '0;
    ctrl_rx_valid = 1'b0;
    ctrl_eot      = 1'b0;
    cap_n         = 0;
    test_reset();
    test_atomic_wr();
    test_rpt_payload();
    test_round_robin();
    test_rx_route();
    test_skip_eot();
    test_sw_rst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
